// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding and fixed
// address constants used by the controller and its target-alignment helper.
package fetch_controller_pkg;

    localparam int unsigned XLEN = 32;

    // Redirect destination used when a misaligned branch target is trapped.
    localparam logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0010;
    // Sequential fetch stride.
    localparam logic [XLEN-1:0] PC_INCREMENT = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_t;

endpackage : fetch_controller_pkg

// File: rtl/fetch_controller_target_align.sv
// target_align: combinational resolution of a branch redirect address.
// Build option FETCH_ALIGN_CHECK_EN:
//   defined   - a target with bits[1:0] != 0 resolves to TRAP_VECTOR and
//               raises misaligned_o.
//   undefined - bits[1:0] of the target are cleared; misaligned_o is 0.
// Ports:
//   target_i     raw redirect address from execute
//   resolved_o   address actually used for the redirect
//   misaligned_o target was not word aligned (only with the check enabled)
module target_align
    import fetch_controller_pkg::*;
(
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] resolved_o,
    output logic            misaligned_o
);

`ifdef FETCH_ALIGN_CHECK_EN
    always_comb begin
        misaligned_o = (target_i[1:0] != 2'b00);
        resolved_o   = misaligned_o ? TRAP_VECTOR : target_i;
    end
`else
    // Masking keeps every target bit in the expression while forcing word alignment.
    always_comb begin
        misaligned_o = 1'b0;
        resolved_o   = target_i & ~XLEN'(32'h3);
    end
`endif

endmodule : target_align

// File: rtl/fetch_controller.sv
// fetch_controller: decides each cycle whether and where the program counter
// advances, handling boot, sequential fetch, branch redirects and redirects
// that arrive while fetch is stalled (held in a pending register).
// Build option FETCH_ALIGN_CHECK_EN selects trap-on-misaligned-target
// behaviour in target_align (see that file).
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   Stall, Mem_Ready  hazard freeze request / memory accepts an address
//   Branch_Taken,
//   Branch_Target     single-cycle redirect request and its address
//   PC_Current        current program counter value
//   PC_En, PC_Next    program counter write enable and next value
//   Flush             kill IF/ID contents this cycle
//   Fetch_Valid       instruction at PC_Current is valid for decode
//   Misaligned_Fault  pulse on a trapped misaligned redirect
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
)
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            Stall,
    input  logic            Mem_Ready,
    input  logic            Branch_Taken,
    input  logic [XLEN-1:0] Branch_Target,
    input  logic [XLEN-1:0] PC_Current,
    output logic            PC_En,
    output logic [XLEN-1:0] PC_Next,
    output logic            Flush,
    output logic            Fetch_Valid,
    output logic            Misaligned_Fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            adv_c;
    logic [XLEN-1:0] resolved_c;
    logic            misaligned_c;

    assign adv_c = !Stall && Mem_Ready;

    target_align u_target_align (
        .target_i     (Branch_Target),
        .resolved_o   (resolved_c),
        .misaligned_o (misaligned_c)
    );

    // State and pending-target registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_BOOT;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        pend_d           = pend_q;
        PC_En            = 1'b0;
        PC_Next          = PC_Current + PC_INCREMENT;
        Flush            = 1'b0;
        Fetch_Valid      = 1'b0;
        Misaligned_Fault = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Redirects are ignored until the reset vector has been issued.
                PC_En   = 1'b1;
                PC_Next = RESET_VECTOR;
                state_d = ST_RUN;
            end
            ST_RUN, ST_PEND: begin
                if (Branch_Taken) begin
                    // Newest redirect always wins, even over an older pending one.
                    Flush            = 1'b1;
                    Misaligned_Fault = misaligned_c;
                    if (adv_c) begin
                        PC_En   = 1'b1;
                        PC_Next = resolved_c;
                        state_d = ST_RUN;
                    end else begin
                        pend_d  = resolved_c;
                        state_d = ST_PEND;
                    end
                end else if (state_q == ST_PEND) begin
                    if (adv_c) begin
                        PC_En   = 1'b1;
                        PC_Next = pend_q;
                        state_d = ST_RUN;
                    end
                end else if (adv_c) begin
                    PC_En = 1'b1;
                end
                Fetch_Valid = (state_q == ST_RUN) && Mem_Ready && !Flush;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Reset dominates every output and the next state.
        if (RST) begin
            state_d          = ST_BOOT;
            pend_d           = '0;
            PC_En            = 1'b0;
            PC_Next          = RESET_VECTOR;
            Flush            = 1'b0;
            Fetch_Valid      = 1'b0;
            Misaligned_Fault = 1'b0;
        end
    end

endmodule : fetch_controller

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios followed by random
// traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_controller;

    logic        CLK;
    logic        RST;
    logic        Stall;
    logic        Mem_Ready;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] PC_Current;
    logic        PC_En;
    logic [31:0] PC_Next;
    logic        Flush;
    logic        Fetch_Valid;
    logic        Misaligned_Fault;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TRAP = 32'h0000_0010;

    fetch_controller #(.RESET_VECTOR(RV)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .Stall            (Stall),
        .Mem_Ready        (Mem_Ready),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .PC_Current       (PC_Current),
        .PC_En            (PC_En),
        .PC_Next          (PC_Next),
        .Flush            (Flush),
        .Fetch_Valid      (Fetch_Valid),
        .Misaligned_Fault (Misaligned_Fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Model: "booting" flag plus a queue holding at most one pending redirect.
    bit          m_boot = 1'b1;
    logic [31:0] m_pend[$];
    logic [31:0] pc_m   = 32'h0;

    function automatic logic [31:0] resolve(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return (t % 4 != 0) ? TRAP : t;
`else
        return t - (t % 4);
`endif
    endfunction

    function automatic bit is_mis(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return (t % 4 != 0);
`else
        return (t == 32'hx); // never true for a known target
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, compare against the model, advance the model.
    task automatic step(input logic rst, input logic stall, input logic mr,
                        input logic bt, input logic [31:0] tgt);
        logic        adv;
        logic        e_en, e_fl, e_fv, e_mf;
        logic [31:0] e_nx;
        RST = rst; Stall = stall; Mem_Ready = mr;
        Branch_Taken = bt; Branch_Target = tgt; PC_Current = pc_m;
        #2;
        adv  = !stall && mr;
        e_nx = pc_m + 32'd4;
        e_en = 1'b0; e_fl = 1'b0; e_fv = 1'b0; e_mf = 1'b0;
        if (rst) begin
            e_nx = RV;
        end else if (m_boot) begin
            e_en = 1'b1; e_nx = RV;
        end else begin
            e_fl = bt;
            e_mf = bt && is_mis(tgt);
            e_fv = (m_pend.size() == 0) && mr && !bt;
            if (bt) begin
                if (adv) begin e_en = 1'b1; e_nx = resolve(tgt); end
            end else if (m_pend.size() != 0) begin
                if (adv) begin e_en = 1'b1; e_nx = m_pend[0]; end
            end else if (adv) begin
                e_en = 1'b1;
            end
        end
        chk("pc_en", 32'(PC_En), 32'(e_en));
        chk("flush", 32'(Flush), 32'(e_fl));
        chk("fetch_valid", 32'(Fetch_Valid), 32'(e_fv));
        chk("mis_fault", 32'(Misaligned_Fault), 32'(e_mf));
        if (e_en || rst) chk("pc_next", PC_Next, e_nx);
        @(posedge CLK);
        if (rst) begin
            m_boot = 1'b1; m_pend.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (bt && !adv) begin
            m_pend.delete(); m_pend.push_back(resolve(tgt));
        end else if (adv) begin
            m_pend.delete();
        end
        if (e_en) pc_m = e_nx;
        #1;
    endtask

    initial begin
        RST = 1'b1; Stall = 1'b0; Mem_Ready = 1'b1;
        Branch_Taken = 1'b0; Branch_Target = '0; PC_Current = '0;

        // Reset then boot and first sequential fetch.
        step(1, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);

        // Wrap at the top of the address space.
        pc_m = 32'hFFFF_FFFC;
        step(0, 0, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Redirect during stall, released after three stalled cycles.
        step(0, 1, 1, 1, 32'h100);
        step(0, 1, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);

        // Newer redirect replaces the pending one.
        step(0, 1, 1, 1, 32'h100);
        step(0, 1, 0, 1, 32'h200);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);

        // Misaligned redirect.
        step(0, 0, 1, 1, 32'h102);
        step(0, 0, 1, 0, 32'h0);

        // Reset while a redirect is pending.
        step(0, 1, 1, 1, 32'h300);
        step(1, 1, 1, 1, 32'h400);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);

        // Boot cycle ignores a redirect.
        step(1, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'h500);
        step(0, 0, 1, 0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_st, r_mr, r_bt;
            logic [31:0] r_tg;
            r_rst = ($urandom_range(0, 99) < 3);
            r_st  = ($urandom_range(0, 99) < 30);
            r_mr  = ($urandom_range(0, 99) < 80);
            r_bt  = ($urandom_range(0, 99) < 20);
            r_tg  = $urandom;
            step(r_rst, r_st, r_mr, r_bt, r_tg);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_fetch_controller
